// File: rtl/gsim_feeder.sv
// rtl/gsim_feeder.sv - stream-to-burst adapter for the GSIM solver core
// Optional feature: define GSIM_FEEDER_TIMEOUT_EN to abort WAIT after TIMEOUT cycles.
module gsim_feeder #(
  parameter int N       = 16,
  parameter int BW      = 16,
  parameter int XW      = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [BW-1:0] s_data,
  output logic          gsim_in_en,
  output logic [BW-1:0] gsim_b_in,
  input  logic [XW-1:0] gsim_x_out,
  input  logic          gsim_out_valid,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [XW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          err
);

  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {LOAD, SEND, WAIT, CAPTURE, DRAIN} state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n, idx_inc;
  logic          idx_last;
  logic [BW-1:0] bbuf [N];
  logic [XW-1:0] xbuf [N];
  logic          x_we;
  logic          timeout_hit;

  logic          in_en_n, m_valid_n, m_last_n, busy_n, err_n;
  logic [BW-1:0] b_in_n;
  logic [XW-1:0] m_data_n;

  assign s_ready  = (state == LOAD);
  assign idx_inc  = idx + IW'(1);
  assign idx_last = (idx == IW'(N-1));

`ifdef GSIM_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  // Cycles spent in WAIT; restarts at zero on every entry.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + TW'(1);
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Right-hand-side buffer fills only on upstream handshakes.
  always_ff @(posedge clk) begin
    if (s_valid && s_ready) bbuf[idx] <= s_data;
  end

  // Solution buffer fills from the GSIM output burst.
  always_ff @(posedge clk) begin
    if (x_we) xbuf[idx] <= gsim_x_out;
  end

  // State, index and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      idx        <= '0;
      gsim_in_en <= 1'b0;
      gsim_b_in  <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      gsim_in_en <= in_en_n;
      gsim_b_in  <= b_in_n;
      m_valid    <= m_valid_n;
      m_data     <= m_data_n;
      m_last     <= m_last_n;
      busy       <= busy_n;
      err        <= err_n;
    end
  end

  // Next state, next index and next values of the registered outputs.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    in_en_n   = 1'b0;
    b_in_n    = '0;
    m_valid_n = m_valid;
    m_data_n  = m_data;
    m_last_n  = m_last;
    err_n     = err;
    x_we      = 1'b0;
    case (state)
      LOAD: begin
        if (s_valid) begin
          idx_n = idx_inc;
          if (idx_last) begin
            // bbuf[0] is already stable, so b1 goes out on the very next cycle.
            state_n = SEND;
            idx_n   = '0;
            in_en_n = 1'b1;
            b_in_n  = bbuf[0];
          end
        end
      end
      SEND: begin
        if (idx_last) begin
          state_n = WAIT;
          idx_n   = '0;
        end else begin
          in_en_n = 1'b1;
          b_in_n  = bbuf[idx_inc];
          idx_n   = idx_inc;
        end
      end
      WAIT: begin
        if (timeout_hit) begin
          err_n   = 1'b1;
          state_n = LOAD;
        end else if (gsim_out_valid) begin
          x_we    = 1'b1;
          idx_n   = IW'(1);
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (gsim_out_valid) begin
          x_we  = 1'b1;
          idx_n = idx_inc;
          if (idx_last) begin
            state_n   = DRAIN;
            idx_n     = '0;
            m_valid_n = 1'b1;
            m_data_n  = xbuf[0];
            m_last_n  = (N == 1);
          end
        end else begin
          // A burst shorter than N words is unusable; flag it and start over.
          err_n   = 1'b1;
          state_n = LOAD;
          idx_n   = '0;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (idx_last) begin
            state_n   = LOAD;
            idx_n     = '0;
            m_valid_n = 1'b0;
            m_data_n  = '0;
            m_last_n  = 1'b0;
          end else begin
            idx_n    = idx_inc;
            m_data_n = xbuf[idx_inc];
            m_last_n = (idx_inc == IW'(N-1));
          end
        end
      end
      default: begin
        state_n = LOAD;
        idx_n   = '0;
      end
    endcase
    busy_n = (state_n != LOAD);
  end

endmodule

// File: tb/tb_gsim_feeder.sv
// tb/tb_gsim_feeder.sv - randomized scoreboard bench for gsim_feeder
module tb_gsim_feeder;

  localparam int N  = 16;
  localparam int BW = 16;
  localparam int XW = 32;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] s_data = '0;
  logic          gsim_in_en;
  logic [BW-1:0] gsim_b_in;
  logic [XW-1:0] gsim_x_out = '0;
  logic          gsim_out_valid = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [XW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          err;

  gsim_feeder #(.N(N), .BW(BW), .XW(XW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .gsim_in_en     (gsim_in_en),
    .gsim_b_in      (gsim_b_in),
    .gsim_x_out     (gsim_x_out),
    .gsim_out_valid (gsim_out_valid),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Transaction-level model: words expected on in_en, words expected on the drain side.
  logic [BW-1:0] exp_b [$];
  logic [XW-1:0] exp_x [$];
  bit            exp_err = 1'b0;
  bit            mon_en = 1'b0;
  bit            prev_stall = 1'b0;
  logic [XW-1:0] prev_data = '0;

  logic [BW-1:0] bvec [N];
  logic [XW-1:0] xvec [N];
  logic [XW-1:0] got_x [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("s_ready_vs_busy", s_ready, !busy);
      chk("err", err, exp_err);
      if (gsim_in_en) begin
        if (exp_b.size() == 0) chk("in_en_unexpected", gsim_in_en, 1'b0);
        else begin
          chk("gsim_b_in", gsim_b_in, exp_b[0]);
          void'(exp_b.pop_front());
        end
      end
      if (m_valid) begin
        if (exp_x.size() == 0) chk("m_valid_unexpected", m_valid, 1'b0);
        else begin
          chk("m_data", m_data, exp_x[0]);
          chk("m_last", m_last, exp_x.size() == 1);
          if (prev_stall) chk("m_data_hold", m_data, prev_data);
          if (m_ready) void'(exp_x.pop_front());
        end
      end else if (prev_stall) begin
        chk("m_valid_dropped", m_valid, 1'b1);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic clear_model();
    exp_b.delete();
    exp_x.delete();
    exp_err    = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    gsim_out_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    clear_model();
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_in_en", gsim_in_en, 1'b0);
    chk("rst_b_in", gsim_b_in, 0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    tick();
  endtask

  // Offer bvec upstream with random gaps and spurious GSIM activity; k = cycle of Nth handshake.
  task automatic load_b(input int gap_pct, output int k);
    k = cyc;
    for (int i = 0; i < N; i++) begin
      bit done = 1'b0;
      int guard = 0;
      while (!done) begin
        s_valid = ($urandom_range(99) >= gap_pct);
        s_data = s_valid ? bvec[i] : BW'($urandom);
        gsim_out_valid = 1'($urandom_range(1));
        gsim_x_out = $urandom;
        @(negedge clk);
        if (s_valid && s_ready) begin
          exp_b.push_back(bvec[i]);
          done = 1'b1;
          k = cyc;
        end
        tick();
        guard++;
        if (!done && guard > 100) begin
          chk("load_stuck", s_ready, 1'b1);
          done = 1'b1;
        end
      end
    end
    s_valid = 1'b0;
    gsim_out_valid = 1'b0;
  endtask

  task automatic send_check(input int k);
    wait_to(k + 1);
    for (int j = 0; j < N; j++) begin
      gsim_out_valid = 1'($urandom_range(1));
      gsim_x_out = $urandom;
      @(negedge clk);
      chk("in_en_burst", gsim_in_en, 1'b1);
      chk("busy_send", busy, 1'b1);
      tick();
    end
    gsim_out_valid = 1'b0;
    @(negedge clk);
    chk("in_en_end", gsim_in_en, 1'b0);
    chk("b_all_sent", exp_b.size(), 0);
    tick();
  endtask

  // GSIM model: nwords of xvec starting d cycles after WAIT entry w.
  task automatic respond(input int w, input int d, input int nwords, output int c);
    wait_to(w + d);
    c = cyc;
    for (int j = 0; j < nwords; j++) begin
      gsim_out_valid = 1'b1;
      gsim_x_out = xvec[j];
      if (nwords == N) exp_x.push_back(xvec[j]);
      tick();
    end
    gsim_out_valid = 1'b0;
    gsim_x_out = $urandom;
    if (nwords < N) begin
      tick();
      exp_err = 1'b1;
      @(negedge clk);
      chk("short_s_ready", s_ready, 1'b1);
      chk("short_m_valid", m_valid, 1'b0);
      chk("short_busy", busy, 1'b0);
      tick();
    end
  endtask

  // mode 0: m_ready high, 1: 1,0,0,1 pattern, 2: random.
  task automatic drain(input int mode, output int first_v, output int last_hs);
    int n = 0;
    int j = 0;
    logic [3:0] pat = 4'b1001;
    first_v = -1;
    last_hs = -1;
    while (n < N && j < 300) begin
      m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[j % 4] : 1'($urandom_range(1));
      s_valid = 1'b1;
      s_data = BW'($urandom);
      gsim_out_valid = 1'($urandom_range(1));
      gsim_x_out = $urandom;
      @(negedge clk);
      chk("s_ready_drain", s_ready, 1'b0);
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        got_x[n] = m_data;
        n++;
        last_hs = cyc;
      end
      tick();
      j++;
    end
    if (n < N) chk("drain_count", n, N);
    m_ready = 1'b0;
    s_valid = 1'b0;
    gsim_out_valid = 1'b0;
    @(negedge clk);
    chk("s_ready_after_drain", s_ready, 1'b1);
    tick();
  endtask

  task automatic randomize_vecs();
    for (int i = 0; i < N; i++) begin
      bvec[i] = BW'($urandom);
      xvec[i] = $urandom;
    end
  endtask

  task automatic run_txn(input int gap, input int d, input int nwords, input int mode);
    int k, c, fv, lh;
    randomize_vecs();
    load_b(gap, k);
    send_check(k);
    respond(k + N + 1, d, nwords, c);
    if (nwords == N) drain(mode, fv, lh);
  endtask

  initial begin
    int k, c, fv, lh, w;
    do_reset();

    // Nominal transaction with literal expectations.
    for (int i = 0; i < N; i++) begin
      bvec[i] = BW'(i + 1);
      xvec[i] = 32'h1000_0000 + XW'(i + 1);
    end
    load_b(0, k);
    send_check(k);
    respond(k + N + 1, 20, N, c);
    drain(0, fv, lh);
    chk("nom_first_valid_cycle", fv, c + N);
    chk("nom_s_ready_cycle", lh + 1, c + 2 * N);
    chk("nom_x1", got_x[0], 32'h1000_0001);
    chk("nom_x16", got_x[15], 32'h1000_0010);
    chk("nom_err", err, 1'b0);

    // Backpressure with the 1,0,0,1 ready pattern.
    run_txn(30, $urandom_range(1, 10), N, 1);
    run_txn(0, 1, N, 2);

    // Short capture burst, then good transactions with err held.
    run_txn(20, $urandom_range(1, 10), 7, 0);
    for (int t = 0; t < 3; t++) run_txn($urandom_range(0, 50), $urandom_range(1, 20), N, 2);
    chk("err_sticky", err, 1'b1);

    // Reset during burst cycle 5 of SEND.
    do_reset();
    randomize_vecs();
    load_b(0, k);
    wait_to(k + 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    chk("midrst_in_en", gsim_in_en, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_s_ready", s_ready, 1'b1);
    tick();
    run_txn(10, $urandom_range(1, 20), N, 2);

    // GSIM never answers.
    randomize_vecs();
    load_b(0, k);
    send_check(k);
    w = k + N + 1;
`ifdef GSIM_FEEDER_TIMEOUT_EN
    wait_to(w + TO - 1);
    @(negedge clk);
    chk("to_busy_before", busy, 1'b1);
    chk("to_s_ready_before", s_ready, 1'b0);
    tick();
    exp_err = 1'b1;
    @(negedge clk);
    chk("to_s_ready", s_ready, 1'b1);
    chk("to_err", err, 1'b1);
    tick();
    run_txn(0, 5, N, 0);
`else
    wait_to(w + 200);
    @(negedge clk);
    chk("no_to_busy", busy, 1'b1);
    chk("no_to_err", err, 1'b0);
    tick();
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog cycle=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
